// File: rtl/ase_sim_local_mem_tg_pkg.sv
// Shared types and helpers for the local-memory Avalon-MM traffic generator.
// Provides the FSM state enum, counter widths and the address-derived data pattern.
package ase_sim_local_mem_tg_pkg;

  localparam int unsigned ERR_CNT_WIDTH     = 16;
  localparam int unsigned NUM_BURSTS_WIDTH  = 16;
  // Only the low 24 line-address bits feed the pattern.
  localparam int unsigned TG_LINE_W         = 24;
  // Widest data bus the pattern helper supports; callers truncate to DATA_WIDTH.
  localparam int unsigned TG_MAX_DATA_WIDTH = 2048;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    FIN
  } t_tg_state;

  // Lane i of line A is {A[23:0], i[7:0]} ^ seed.
  function automatic logic [TG_MAX_DATA_WIDTH-1:0] tg_pattern(
    input logic [TG_LINE_W-1:0] line,
    input logic [31:0]          seed
  );
    logic [TG_MAX_DATA_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < int'(TG_MAX_DATA_WIDTH / 32); i++) begin
      p[i*32 +: 32] = {line, 8'(i)} ^ seed;
    end
    return p;
  endfunction

endpackage

// File: rtl/ase_sim_local_mem_tg_checker.sv
// Read-data checker: tracks the expected line for each returned beat, compares
// against the pattern one cycle later and counts mismatches (saturating).
// Ports: clk, reset_n, clear (new test), base (first line), beat_valid/beat_data
// (accepted read beats), error_count, first_err_addr.
// Macro ASE_LOCAL_MEM_TG_ERR_LOG_EN enables first-mismatch address capture;
// otherwise first_err_addr is tied to 0.
module ase_sim_local_mem_tg_checker
  import ase_sim_local_mem_tg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned EXP_W      = 24,
  parameter logic [31:0] SEED       = 32'h5EED_C0DE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [EXP_W-1:0]         base,
  input  logic                     beat_valid,
  input  logic [DATA_WIDTH-1:0]    beat_data,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr
);

  logic [EXP_W-1:0]      exp_q;
  logic                  mis_q;
  logic [DATA_WIDTH-1:0] exp_data_c;

  assign exp_data_c = DATA_WIDTH'(tg_pattern(exp_q[TG_LINE_W-1:0], SEED));

  // Expected-line counter, registered compare and saturating error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q       <= '0;
      mis_q       <= 1'b0;
      error_count <= '0;
    end else if (clear) begin
      exp_q       <= base;
      mis_q       <= 1'b0;
      error_count <= '0;
    end else begin
      if (beat_valid) exp_q <= exp_q + EXP_W'(1);
      mis_q <= beat_valid && (beat_data != exp_data_c);
      if (mis_q && (error_count != '1)) error_count <= error_count + ERR_CNT_WIDTH'(1);
    end
  end

`ifdef ASE_LOCAL_MEM_TG_ERR_LOG_EN
  logic [ADDR_WIDTH-1:0] mis_addr_q;
  logic                  have_err_q;

  // Line address travels alongside the registered compare; first one sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_addr_q     <= '0;
      have_err_q     <= 1'b0;
      first_err_addr <= '0;
    end else if (clear) begin
      mis_addr_q     <= '0;
      have_err_q     <= 1'b0;
      first_err_addr <= '0;
    end else begin
      if (beat_valid) mis_addr_q <= ADDR_WIDTH'(exp_q);
      if (mis_q && !have_err_q) begin
        first_err_addr <= mis_addr_q;
        have_err_q     <= 1'b1;
      end
    end
  end
`else
  assign first_err_addr = '0;
`endif

endmodule

// File: rtl/ase_sim_local_mem_avmm_traffic_gen.sv
// Avalon-MM memory exerciser: writes NUM_BURSTS bursts of an address-derived
// pattern, reads the region back under a read-credit limit and checks each beat.
// Ports: clk, reset_n, start, cfg_base_addr/cfg_num_bursts/cfg_burst_len (latched
// at start), busy, done, error_count, first_err_addr, Avalon-MM master command
// (address, burstcount, write, writedata, byteenable, read), waitrequest,
// readdata, readdatavalid.
// Macro ASE_LOCAL_MEM_TG_ERR_LOG_EN enables first-mismatch address capture.
module ase_sim_local_mem_avmm_traffic_gen
  import ase_sim_local_mem_tg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned MAX_RD_OUTST    = 64,
  parameter logic [31:0] SEED            = 32'h5EED_C0DE
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic [NUM_BURSTS_WIDTH-1:0] cfg_num_bursts,
  input  logic [BURST_CNT_WIDTH-1:0]  cfg_burst_len,
  output logic                        busy,
  output logic                        done,
  output logic [ERR_CNT_WIDTH-1:0]    error_count,
  output logic [ADDR_WIDTH-1:0]       first_err_addr,
  output logic [ADDR_WIDTH-1:0]       address,
  output logic [BURST_CNT_WIDTH-1:0]  burstcount,
  output logic                        write,
  output logic [DATA_WIDTH-1:0]       writedata,
  output logic [DATA_WIDTH/8-1:0]     byteenable,
  output logic                        read,
  input  logic                        waitrequest,
  input  logic [DATA_WIDTH-1:0]       readdata,
  input  logic                        readdatavalid
);

  localparam int unsigned CRD_W = $clog2(MAX_RD_OUTST + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
`ifdef ASE_LOCAL_MEM_TG_ERR_LOG_EN
  localparam int unsigned EXP_W = ADDR_WIDTH;
`else
  localparam int unsigned EXP_W = TG_LINE_W;
`endif
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_RD_OUTST);

  t_tg_state                   state_q, state_n;
  logic [ADDR_WIDTH-1:0]       base_q, base_n, baddr_q, baddr_n, next_baddr_c, wr_line_c;
  logic [NUM_BURSTS_WIDTH-1:0] nb_q, nb_n, bidx_q, bidx_n;
  logic [BURST_CNT_WIDTH-1:0]  len_q, len_n, beat_q, beat_n, cfg_len_c;
  logic [CRD_W-1:0]            crd_q, crd_n, crd_after_c;
  logic [ADDR_WIDTH-1:0]       address_n;
  logic [BURST_CNT_WIDTH-1:0]  burstcount_n;
  logic [DATA_WIDTH-1:0]       writedata_n;
  logic                        write_n, read_n, busy_n, done_n;
  logic                        wr_acc_c, rd_acc_c, rsp_c, start_acc_c;

  assign cfg_len_c    = (cfg_burst_len == '0) ? BURST_CNT_WIDTH'(1) : cfg_burst_len;
  assign next_baddr_c = baddr_q + ADDR_WIDTH'(len_q);
  assign wr_line_c    = baddr_q + ADDR_WIDTH'(beat_q) + ADDR_WIDTH'(1);
  assign wr_acc_c     = write && !waitrequest;
  assign rd_acc_c     = read && !waitrequest;
  // Responses only count while a read phase is active.
  assign rsp_c        = readdatavalid && ((state_q == RD) || (state_q == DRAIN));
  assign start_acc_c  = (state_q == IDLE) && start;
  assign crd_after_c  = crd_q - (rd_acc_c ? CRD_W'(len_q) : CRD_W'(0))
                              + (rsp_c ? CRD_W'(1) : CRD_W'(0));

  // Next-state and next-output logic; command outputs hold unless accepted.
  always_comb begin
    state_n      = state_q;
    base_n       = base_q;
    baddr_n      = baddr_q;
    nb_n         = nb_q;
    bidx_n       = bidx_q;
    len_n        = len_q;
    beat_n       = beat_q;
    crd_n        = crd_after_c;
    address_n    = address;
    burstcount_n = burstcount;
    writedata_n  = writedata;
    write_n      = write;
    read_n       = read;
    busy_n       = busy;
    done_n       = done;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_n       = cfg_base_addr;
          baddr_n      = cfg_base_addr;
          nb_n         = cfg_num_bursts;
          len_n        = cfg_len_c;
          bidx_n       = '0;
          beat_n       = '0;
          crd_n        = CRD_MAX;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          address_n    = cfg_base_addr;
          burstcount_n = cfg_len_c;
          if (cfg_num_bursts == '0) begin
            state_n = FIN;
          end else begin
            state_n     = WR;
            write_n     = 1'b1;
            writedata_n = DATA_WIDTH'(tg_pattern(cfg_base_addr[TG_LINE_W-1:0], SEED));
          end
        end
      end
      WR: begin
        if (wr_acc_c) begin
          if (beat_q != len_q - BURST_CNT_WIDTH'(1)) begin
            beat_n      = beat_q + BURST_CNT_WIDTH'(1);
            writedata_n = DATA_WIDTH'(tg_pattern(wr_line_c[TG_LINE_W-1:0], SEED));
          end else if (bidx_q != nb_q - NUM_BURSTS_WIDTH'(1)) begin
            bidx_n      = bidx_q + NUM_BURSTS_WIDTH'(1);
            beat_n      = '0;
            baddr_n     = next_baddr_c;
            address_n   = next_baddr_c;
            writedata_n = DATA_WIDTH'(tg_pattern(next_baddr_c[TG_LINE_W-1:0], SEED));
          end else begin
            state_n   = RD;
            write_n   = 1'b0;
            bidx_n    = '0;
            baddr_n   = base_q;
            address_n = base_q;
            read_n    = 32'(crd_q) >= 32'(len_q);
          end
        end
      end
      RD: begin
        if (rd_acc_c) begin
          if (bidx_q == nb_q - NUM_BURSTS_WIDTH'(1)) begin
            state_n = DRAIN;
            read_n  = 1'b0;
          end else begin
            bidx_n    = bidx_q + NUM_BURSTS_WIDTH'(1);
            baddr_n   = next_baddr_c;
            address_n = next_baddr_c;
            read_n    = 32'(crd_after_c) >= 32'(len_q);
          end
        end else if (!read) begin
          read_n = 32'(crd_after_c) >= 32'(len_q);
        end
      end
      DRAIN: begin
        if (crd_q == CRD_MAX) state_n = FIN;
      end
      FIN: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      baddr_q    <= '0;
      nb_q       <= '0;
      bidx_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      crd_q      <= '0;
      address    <= '0;
      burstcount <= '0;
      writedata  <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byteenable <= '0;
    end else begin
      state_q    <= state_n;
      base_q     <= base_n;
      baddr_q    <= baddr_n;
      nb_q       <= nb_n;
      bidx_q     <= bidx_n;
      len_q      <= len_n;
      beat_q     <= beat_n;
      crd_q      <= crd_n;
      address    <= address_n;
      burstcount <= burstcount_n;
      writedata  <= writedata_n;
      write      <= write_n;
      read       <= read_n;
      busy       <= busy_n;
      done       <= done_n;
      byteenable <= {BE_W{busy_n}};
    end
  end

  ase_sim_local_mem_tg_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .EXP_W      (EXP_W),
    .SEED       (SEED)
  ) u_checker (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (start_acc_c),
    .base           (EXP_W'(cfg_base_addr)),
    .beat_valid     (rsp_c),
    .beat_data      (readdata),
    .error_count    (error_count),
    .first_err_addr (first_err_addr)
  );

endmodule
